// File: rtl/subtractor_borrow_seq_pkg.sv
// Shared definitions for the chunked borrow-ripple subtractor: FSM state
// encoding and the default geometry (N, W and chunk count C = N/W).
package subtractor_borrow_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int N_DEF = 16;
    localparam int W_DEF = 4;
    localparam int C_DEF = N_DEF / W_DEF;

    // Number of W-bit chunks in an N-bit operand.
    function automatic int num_chunks(input int n, input int w);
        return n / w;
    endfunction

endpackage

// File: rtl/subtractor_borrow_seq_chunk.sv
// W-bit subtract-with-borrow: {bout, d} = x - y - bin, evaluated over W+1 bits.
module sub_chunk_borrow #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] full;

    // The extra top bit goes to 1 exactly when the difference underflows.
    always_comb begin
        full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
        d    = full[W-1:0];
        bout = full[W];
    end

endmodule

// File: rtl/subtractor_borrow_seq.sv
// Sequential N-bit unsigned subtractor: one W-bit chunk per clock, LSB chunk
// first, borrow carried between chunks in a register.
module subtractor_borrow_seq
    import subtractor_borrow_seq_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done_tick,
    output logic [N-1:0] diff,
    output logic         bout
);

    localparam int C  = num_chunks(N, W);
    localparam int IW = (C > 1) ? $clog2(C) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(C - 1);

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d;
    logic [N-1:0]    work_q, work_d;
    logic [N-1:0]    diff_q, diff_d;
    logic            borrow_q, borrow_d;
    logic            bout_q, bout_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic [W-1:0]    a_chunk, b_chunk, chunk_d;
    logic            chunk_bout;

    // Constant-index chunk mux keeps every part-select static.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int c = 0; c < C; c++) begin
            if (idx_q == IW'(c)) begin
                a_chunk = a_q[c*W +: W];
                b_chunk = b_q[c*W +: W];
            end
        end
    end

    sub_chunk_borrow #(
        .W(W)
    ) u_chunk (
        .x   (a_chunk),
        .y   (b_chunk),
        .bin (borrow_q),
        .d   (chunk_d),
        .bout(chunk_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        idx_d    = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_OP;
                    a_d      = a;
                    b_d      = b;
                    work_d   = '0;
                    borrow_d = 1'b0;
                    idx_d    = '0;
                end
            end
            ST_OP: begin
                for (int c = 0; c < C; c++) begin
                    if (idx_q == IW'(c)) begin
                        work_d[c*W +: W] = chunk_d;
                    end
                end
                borrow_d = chunk_bout;
                idx_d    = idx_q + IW'(1);
                // Outputs are published only together with the final chunk.
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    diff_d  = work_d;
                    bout_d  = chunk_bout;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            idx_q    <= idx_d;
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign done_tick = (state_q == ST_DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_subtractor_borrow_seq.sv
// Self-checking bench for subtractor_borrow_seq: directed vector table,
// multi-cycle corner sequences and randomized operations against a model.
module tb_subtractor_borrow_seq;
    import subtractor_borrow_seq_pkg::*;

    localparam int N = N_DEF;
    localparam int W = W_DEF;
    localparam int C = C_DEF;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] a, b;
    logic         ready, done_tick, bout;
    logic [N-1:0] diff;

    always #5 clk = ~clk;

    subtractor_borrow_seq #(
        .N(N),
        .W(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done_tick(done_tick),
        .diff     (diff),
        .bout     (bout)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] diff;
        logic         bout;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain unsigned arithmetic on the whole operands.
    function automatic logic [N:0] ref_sub(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N-1:0] d;
        d = N'((x + (1 << N) - y) % (1 << N));
        return {(x < y) ? 1'b1 : 1'b0, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 20) begin
            step();
            n++;
        end
        if (!ready) check("wait_ready_timeout", 32'(ready), 32'd1);
    endtask

    // One full operation: accept, scramble inputs, time done_tick, check result.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input string name);
        logic [N:0] exp;
        int lat;
        logic busy_bad;
        exp = ref_sub(ta, tb_v);
        wait_ready();
        a = ta;
        b = tb_v;
        start = 1'b1;
        step();
        start = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        lat = -1;
        busy_bad = 1'b0;
        for (int i = 1; i <= 4 * C + 4; i++) begin
            if (ready) busy_bad = 1'b1;
            if (done_tick) begin
                lat = i - 1;
                break;
            end
            step();
        end
        check({name, "_latency"}, 32'(lat), 32'(C));
        check({name, "_busy"}, 32'(busy_bad), 32'd0);
        check({name, "_diff"}, 32'(diff), 32'(exp[N-1:0]));
        check({name, "_bout"}, 32'(bout), 32'(exp[N]));
        step();
        check({name, "_idle"}, 32'(ready), 32'd1);
    endtask

    initial begin
        logic [N:0] e;
        int dones;
        int done_at[$];

        vecs[0] = '{a: 16'h1234, b: 16'h0234, diff: 16'h1000, bout: 1'b0};
        vecs[1] = '{a: 16'h0000, b: 16'h0001, diff: 16'hFFFF, bout: 1'b1};
        vecs[2] = '{a: 16'h1000, b: 16'h0001, diff: 16'h0FFF, bout: 1'b0};
        vecs[3] = '{a: 16'hABCD, b: 16'hABCD, diff: 16'h0000, bout: 1'b0};
        vecs[4] = '{a: 16'h8000, b: 16'h7FFF, diff: 16'h0001, bout: 1'b0};
        vecs[5] = '{a: 16'h7FFF, b: 16'h8000, diff: 16'hFFFF, bout: 1'b1};

        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done_tick), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        reset = 1'b0;
        step();
        check("post_rst_ready", 32'(ready), 32'd1);

        // Directed vectors: expected values are hand-written constants.
        for (int v = 0; v < 6; v++) begin
            e = {vecs[v].bout, vecs[v].diff};
            check($sformatf("vec%0d_model", v), 32'(ref_sub(vecs[v].a, vecs[v].b)), 32'(e));
            run_op(vecs[v].a, vecs[v].b, $sformatf("vec%0d", v));
        end

        // Re-pulsed start during OP must be ignored.
        wait_ready();
        a = 16'h1000;
        b = 16'h0001;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        a = 16'hFFFF;
        b = 16'h0000;
        start = 1'b1;
        step();
        check("repulse_ready", 32'(ready), 32'd0);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_tick) begin
                dones++;
                check("repulse_diff", 32'(diff), 32'h0FFF);
                check("repulse_bout", 32'(bout), 32'd0);
                check("repulse_done_ready", 32'(ready), 32'd0);
            end
            step();
        end
        check("repulse_dones", 32'(dones), 32'd1);
        check("hold_diff", 32'(diff), 32'h0FFF);

        // Asynchronous reset in the middle of OP aborts without done_tick.
        run_op(16'h1234, 16'h0234, "pre_abort");
        a = 16'h00FF;
        b = 16'h0F00;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #3 reset = 1'b1;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        check("abort_done", 32'(done_tick), 32'd0);
        #1 reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done_tick) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_op(16'd5, 16'd7, "after_abort");

        // Start held high: model the accept/done schedule from the protocol.
        wait_ready();
        a = 16'h00FF;
        b = 16'h0100;
        start = 1'b1;
        e = ref_sub(a, b);
        for (int j = 0; j < 20; j++) begin
            step();
            if (done_tick) begin
                done_at.push_back(j);
                check($sformatf("held_diff%0d", j), 32'(diff), 32'(e[N-1:0]));
                check($sformatf("held_bout%0d", j), 32'(bout), 32'(e[N]));
            end
        end
        start = 1'b0;
        check("held_count", 32'(done_at.size()), 32'd3);
        for (int k = 0; k < done_at.size(); k++) begin
            check($sformatf("held_pos%0d", k), 32'(done_at[k]), 32'(C + k * (C + 2)));
        end
        wait_ready();

        // Randomized operations against the model.
        for (int r = 0; r < 30; r++) begin
            run_op(N'($urandom), N'($urandom), $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/subtractor_borrow_seq.md
SUBTRACTOR_BORROW_SEQ -- requirements
Module: subtractor_borrow_seq

Interface
REQ-001 SHALL have parameter N, default 16: operand and result width in bits.
REQ-002 SHALL have parameter W, default 4: chunk width processed per clock; N SHALL be an integer multiple of W, with W <= N.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only while ready=1.
REQ-006 SHALL have ports a and b, input, N bits each: unsigned minuend and subtrahend; sampled on the edge that accepts start.
REQ-007 SHALL have port ready, output, 1 bit: high only in state IDLE.
REQ-008 SHALL have port done_tick, output, 1 bit: one-cycle pulse, high only in state DONE.
REQ-009 SHALL have port diff, output, N bits: registered result a-b mod 2^N.
REQ-010 SHALL have port bout, output, 1 bit: registered borrow-out, 1 iff a < b unsigned.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, OP, DONE.
REQ-012 Transitions SHALL be:
- IDLE -> OP when start=1; a and b are latched, the internal borrow is cleared and the chunk index is set to 0.
- OP -> OP while the chunk index < C-1, where C = N/W.
- OP -> DONE on the edge that processes chunk C-1.
- DONE -> IDLE unconditionally.
REQ-013 Each OP edge SHALL compute {borrow_next, d} = a_chunk[i] - b_chunk[i] - borrow over W+1 bits, write d into bits [i*W+W-1 : i*W] of the working result, store borrow_next, and increment i.
REQ-014 Chunk 0 SHALL be the least-significant W bits; the borrow SHALL propagate LSB to MSB.
REQ-015 diff and bout SHALL update only on the edge that enters DONE, and SHALL hold until the next operation completes.
REQ-016 Latency SHALL be fixed: with start accepted at edge k, done_tick is high in the cycle after edge k+C (C+1 cycles start-to-idle, including the DONE cycle).
REQ-017 start while ready=0 SHALL be ignored; changes on a or b outside the accepting edge SHALL have no effect.
REQ-018 start held high continuously SHALL begin a new operation on the first edge after DONE returns to IDLE.
REQ-019 When W=N (C=1), the block SHALL pass through OP for exactly one cycle.
REQ-020 Overflow SHALL not exist: the result wraps mod 2^N, and bout reports the borrow.

Reset
REQ-021 On reset=1, regardless of the clock, the block SHALL enter IDLE and force ready=1, done_tick=0, diff=0, bout=0, and clear the working registers, borrow and index.
REQ-022 Reset asserted mid-OP SHALL abort the operation with no done_tick; after release, the first start SHALL run normally.

Structure
REQ-023 The state encoding and the derived constant C=N/W SHALL live in a shared header with localparams, included by the RTL and the bench.
REQ-024 The per-chunk W-bit subtract-with-borrow SHALL be one combinational sub-module, sub_chunk_borrow, with parameter W, inputs x[W-1:0], y[W-1:0] and bin, and outputs d[W-1:0] and bout.
REQ-025 The top level SHALL contain the FSM, the chunk index counter, the borrow register, and the operand and result registers.

Verification (N=16, W=4, C=4)
REQ-026 a=0x1234, b=0x0234, start pulse -> done_tick exactly 4 cycles after the accepting edge; diff=0x1000, bout=0.
REQ-027 a=0x0000, b=0x0001 -> diff=0xFFFF, bout=1 (borrow ripples through all 4 chunks).
REQ-028 a=0x1000, b=0x0001 -> diff=0x0FFF, bout=0; then a=b=0xABCD -> diff=0x0000, bout=0.
REQ-029 start re-pulsed with a=0xFFFF, b=0 during OP -> ignored; first result is unchanged; ready=0 throughout OP and DONE.
REQ-030 reset asserted at OP cycle 2 -> ready=1, diff=0, bout=0 immediately with no done_tick; a following a=5, b=7 -> diff=0xFFFE, bout=1.
REQ-031 start held high for 20 cycles -> back-to-back operations with a period of C+2=6 cycles, each with exactly one done_tick.
